// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: circular FIFO plus issue FSM in front of a UART transmitter.
// Ports: source valid/ready in (s_*), one-cycle issue out (uart_tx_en/data), busy in, status out.
module uart_tx_feeder #(
  parameter int PAYLOAD_BITS = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         s_valid,
  input  logic [PAYLOAD_BITS-1:0]      s_data,
  output logic                         s_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]      uart_tx_data,
  input  logic                         uart_tx_busy,
  output logic                         tx_idle,
  output logic                         ack_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t state, state_n;

  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             level;
  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    issue;

  logic [TW-1:0]           timer, timer_n;
  logic                    en_n;
  logic [PAYLOAD_BITS-1:0] data_n;
  logic                    err_n;

  assign empty      = (level == '0);
  assign full       = (level == (AW+1)'(FIFO_DEPTH));
  assign s_ready    = !full;
  assign fifo_level = level;
  assign push       = s_valid && !full && !flush;
  assign tx_idle    = empty && (state == IDLE) && !uart_tx_busy;

  // Storage needs no reset; pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push}
                     - {{AW{1'b0}}, issue};
    end
  end

  always_comb begin
    state_n = state;
    en_n    = 1'b0;
    data_n  = uart_tx_data;
    timer_n = timer;
    err_n   = ack_err;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !uart_tx_busy && !flush) begin
          issue   = 1'b1;
          en_n    = 1'b1;
          data_n  = mem[rd_ptr];
          timer_n = '0;
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (uart_tx_busy) begin
          state_n = WAIT_DONE;
        end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
          // Transmitter never took the word; drop it.
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_tx_busy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      timer        <= '0;
      ack_err      <= 1'b0;
    end else begin
      state        <= state_n;
      uart_tx_en   <= en_n;
      uart_tx_data <= data_n;
      timer        <= timer_n;
      ack_err      <= err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench for uart_tx_feeder.
// Uses a behavioural transmitter (short bit time) and a line receiver.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int CPB   = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       flush;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [4:0] fifo_level;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       uart_tx_busy;
  logic       tx_idle;
  logic       ack_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_q[$];
  logic [7:0] rx_got[$];
  int         en_times[$];
  int         cyc = 0;
  int         en_count = 0;
  int         max_level = 0;
  int         ack_cyc = -1;
  logic       prev_en = 1'b0;
  logic [7:0] exp_d;

  logic       busy_mode;
  logic       busy_force;
  logic       m_busy;
  logic       line;

  assign uart_tx_busy = busy_mode ? busy_force : m_busy;

  always #5 clk = ~clk;

  uart_tx_feeder #(
    .PAYLOAD_BITS(8),
    .FIFO_DEPTH(DEPTH),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .fifo_level(fifo_level),
    .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_busy(uart_tx_busy),
    .tx_idle(tx_idle),
    .ack_err(ack_err)
  );

  always @(posedge clk) cyc++;

  // Behavioural transmitter: 8N1, CPB clocks per bit.
  logic [9:0] shreg;
  int         bitcnt;
  int         clkcnt;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy <= 1'b0;
      shreg  <= '1;
      bitcnt <= 0;
      clkcnt <= 0;
    end else if (!m_busy) begin
      if (uart_tx_en && !busy_mode) begin
        m_busy <= 1'b1;
        shreg  <= {1'b1, uart_tx_data, 1'b0};
        bitcnt <= 0;
        clkcnt <= 0;
      end
    end else if (clkcnt == CPB - 1) begin
      clkcnt <= 0;
      shreg  <= {1'b1, shreg[9:1]};
      if (bitcnt == 9) m_busy <= 1'b0;
      else bitcnt <= bitcnt + 1;
    end else begin
      clkcnt <= clkcnt + 1;
    end
  end

  assign line = m_busy ? shreg[0] : 1'b1;

  // Line receiver: mid-bit sampling.
  logic       rx_act = 1'b0;
  int         rx_cnt;
  int         rx_k;
  logic [7:0] rx_byte;
  logic       rx_stop_bad = 1'b0;

  always @(posedge clk) begin
    if (!rx_act) begin
      if (resetn === 1'b1 && line === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 1;
        rx_k   = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB/2 + rx_k*CPB) begin
        if (rx_k >= 1 && rx_k <= 8) rx_byte[rx_k-1] = line;
        if (rx_k == 9) begin
          if (line !== 1'b1) rx_stop_bad = 1'b1;
          rx_got.push_back(rx_byte);
          rx_act = 1'b0;
        end
        rx_k++;
      end
    end
  end

  // Issue monitor: scoreboard pop and issue-rule checks.
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (ack_err === 1'b1 && ack_cyc < 0) ack_cyc = cyc;
      if (uart_tx_en === 1'b1) begin
        en_count++;
        en_times.push_back(cyc);
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected data=%h", uart_tx_data);
        end else begin
          exp_d = sb_q.pop_front();
          if (uart_tx_data !== exp_d) begin
            errors++;
            $display("FAIL issue_data got=%h exp=%h", uart_tx_data, exp_d);
          end
        end
        checks++;
        if (uart_tx_busy !== 1'b0 || prev_en !== 1'b0) begin
          errors++;
          $display("FAIL en_guard busy=%b prev_en=%b exp both 0",
                   uart_tx_busy, prev_en);
        end
      end
      prev_en = uart_tx_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = s_ready && !flush;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid = 1'b0;
    if (acc) begin
      sb_q.push_back(d);
    end else begin
      checks++;
      errors++;
      $display("FAIL push_timeout data=%h s_ready=%b exp 1", d, s_ready);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (tx_idle) break;
      n++;
    end
    checks++;
    if (tx_idle !== 1'b1) begin
      errors++;
      $display("FAIL idle_timeout tx_idle=%b exp 1", tx_idle);
    end
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    flush = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    busy_mode = 1'b0;
    busy_force = 1'b0;
    repeat (3) step();
    checks++;
    if (fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", s_ready); end
    checks++;
    if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", uart_tx_en); end
    checks++;
    if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", uart_tx_data); end
    checks++;
    if (ack_err !== 1'b0) begin errors++; $display("FAIL rst_ack_err got=%b exp=0", ack_err); end
    checks++;
    if (tx_idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%b exp=1", tx_idle); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit found;
    found = 1'b0;
    push(8'hA5);
    for (int i = 0; i < 2 && !found; i++) begin
      @(negedge clk);
      if (uart_tx_en) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL single_latency en=%b exp 1 within 2 cycles", uart_tx_en); end
    checks++;
    if (uart_tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", uart_tx_data); end
    checks++;
    if (fifo_level !== 5'd0) begin errors++; $display("FAIL single_level got=%0d exp=0", fifo_level); end
    step();
    wait_idle(200);
  endtask

  task automatic test_full();
    int n;
    busy_mode = 1'b1;
    busy_force = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i));
    checks++;
    if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_level got=%0d exp=16", fifo_level); end
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", s_ready); end
    s_valid = 1'b1;
    s_data = 8'hEE;
    step();
    s_valid = 1'b0;
    checks++;
    if (fifo_level !== 5'd16) begin errors++; $display("FAIL full_17th got=%0d exp=16", fifo_level); end
    n = en_count;
    busy_mode = 1'b0;
    wait_idle(2500);
    checks++;
    if (en_count - n != DEPTH) begin errors++; $display("FAIL full_drain_count got=%0d exp=%0d", en_count - n, DEPTH); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL full_sb_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_wrap();
    int n;
    n = en_count;
    max_level = 0;
    for (int i = 0; i < 20; i++) push(8'($urandom));
    wait_idle(2500);
    checks++;
    if (en_count - n != 20) begin errors++; $display("FAIL wrap_count got=%0d exp=20", en_count - n); end
    checks++;
    if (max_level > DEPTH) begin errors++; $display("FAIL wrap_max_level got=%0d exp<=16", max_level); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_sb_left got=%0d exp=0", sb_q.size()); end
  endtask

  task automatic test_pair();
    rx_got.delete();
    rx_stop_bad = 1'b0;
    push(8'h55);
    push(8'h0F);
    wait_idle(400);
    checks++;
    if (rx_got.size() != 2) begin
      errors++;
      $display("FAIL pair_frames got=%0d exp=2", rx_got.size());
    end else begin
      checks++;
      if (rx_got[0] !== 8'h55) begin errors++; $display("FAIL pair_byte0 got=%h exp=55", rx_got[0]); end
      checks++;
      if (rx_got[1] !== 8'h0F) begin errors++; $display("FAIL pair_byte1 got=%h exp=0f", rx_got[1]); end
    end
    checks++;
    if (rx_stop_bad !== 1'b0) begin errors++; $display("FAIL pair_stop got=%b exp=0", rx_stop_bad); end
  endtask

  task automatic test_timeout();
    int n0;
    int n;
    busy_mode = 1'b1;
    busy_force = 1'b0;
    n0 = en_times.size();
    push(8'h3C);
    push(8'hC3);
    n = 0;
    while (en_times.size() < n0 + 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (en_times.size() < n0 + 2) begin
      errors++;
      $display("FAIL timeout_reissue got=%0d exp=2 issues", en_times.size() - n0);
    end else begin
      checks++;
      if (ack_cyc - en_times[n0] != 15) begin
        errors++;
        $display("FAIL timeout_ack_delay got=%0d exp=15", ack_cyc - en_times[n0]);
      end
      checks++;
      if (en_times[n0+1] - en_times[n0] != 16) begin
        errors++;
        $display("FAIL timeout_next_issue got=%0d exp=16", en_times[n0+1] - en_times[n0]);
      end
    end
    repeat (20) step();
    checks++;
    if (ack_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", ack_err); end
    checks++;
    if (tx_idle !== 1'b1) begin errors++; $display("FAIL timeout_idle got=%b exp=1", tx_idle); end
    busy_mode = 1'b0;
    step();
  endtask

  task automatic test_flush();
    int n;
    rx_got.delete();
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    checks++;
    if (fifo_level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got=%0d exp=5", fifo_level); end
    checks++;
    if (uart_tx_busy !== 1'b1) begin errors++; $display("FAIL flush_inflight got=%b exp=1", uart_tx_busy); end
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 8'h77;
    step();
    flush = 1'b0;
    s_valid = 1'b0;
    sb_q.delete();
    n = en_count;
    checks++;
    if (fifo_level !== 5'd0) begin errors++; $display("FAIL flush_level got=%0d exp=0", fifo_level); end
    checks++;
    if (ack_err !== 1'b1) begin errors++; $display("FAIL flush_ack_err got=%b exp=1", ack_err); end
    wait_idle(200);
    repeat (20) step();
    checks++;
    if (en_count != n) begin errors++; $display("FAIL flush_no_issue got=%0d exp=%0d", en_count, n); end
    checks++;
    if (rx_got.size() != 1) begin
      errors++;
      $display("FAIL flush_frames got=%0d exp=1", rx_got.size());
    end else begin
      checks++;
      if (rx_got[0] !== 8'h60) begin errors++; $display("FAIL flush_frame_data got=%h exp=60", rx_got[0]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_pair();
    test_timeout();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
